row_decoder_5p_plus: RTL and testbench
======================================

ROW_DECODER_5P_PLUS -- requirements
Module: row_decoder_5p_plus

Interface
REQ-001 Parameter: none; all widths fixed (5 pixels x 3 bit, 16-bit packet, 15-bit time fields).
REQ-002 clk  input  1  single clock; all logic on rising edge.
REQ-003 rst_n  input  1  asynchronous reset, active low.
REQ-004 packet_valid  input  1  high = packet_in carries one packet this cycle (one packet per high cycle, back-to-back allowed).
REQ-005 packet_in  input  16  encoded packet from the 5P+ row encoder.
REQ-006 pixel_out  output  15  last decoded 5-pixel group {p4..p0}, 3 bit each; held between updates.
REQ-007 pixel_valid  output  1  one-cycle pulse, pixel_out updated this cycle.
REQ-008 ts_out  output  30  {epoch, low15} wake-up timestamp; held between updates.
REQ-009 ts_valid  output  1  one-cycle pulse, ts_out updated this cycle.
REQ-010 epoch_out  output  15  current time epoch (tik_tok[29:15] as reported by encoder).
REQ-011 epoch_valid  output  1  one-cycle pulse, epoch_out loaded this cycle.
REQ-012 err_pulse  output  1  one-cycle pulse on protocol error.
REQ-013 err_count  output  8  saturating protocol-error count.

Function
REQ-014 Packet classes: RAW = bit15==0 (outside MID_WAIT); WRAP = exactly 16'h8000; TS = bit15==1 and not 16'h8000; MID = any packet received in MID_WAIT.
REQ-015 16'h8000 shall always be decoded as WRAP, never as timestamp 0.
REQ-016 States: IDLE, STREAM, MID_WAIT; reset state IDLE.
REQ-017 IDLE: first packet with packet_valid moves to STREAM (RAW/TS) or MID_WAIT (WRAP) and is decoded identically to STREAM in the same cycle.
REQ-018 STREAM, RAW: pixel_out <= packet_in[14:0], pixel_valid pulse; stay STREAM.
REQ-019 STREAM, TS: ts_out <= {epoch_out, packet_in[14:0]}, ts_valid pulse; stay STREAM.
REQ-020 STREAM, WRAP: no output pulse; go MID_WAIT.
REQ-021 MID_WAIT, packet with bit15==0: epoch_out <= packet_in[14:0], epoch_valid pulse; go STREAM; packet not treated as pixels.
REQ-022 MID_WAIT, WRAP: err_pulse; stay MID_WAIT.
REQ-023 MID_WAIT, TS: err_pulse; pending wrap discarded; packet decoded as TS with current epoch_out; go STREAM.
REQ-024 MID_WAIT with packet_valid low: hold state indefinitely, no timeout.
REQ-025 packet_valid low in any state: no pulses, all held outputs unchanged.
REQ-026 Latency: every output registered; pulse/update appears exactly 1 cycle after the sampling edge of the packet.
REQ-027 At most one of pixel_valid, ts_valid, epoch_valid high in any cycle; err_pulse may coincide with ts_valid (REQ-023).
REQ-028 err_count increments by 1 per err_pulse, saturates at 255, never wraps.
REQ-029 epoch_out before any MID packet is 0; ts_out uses it unchanged.

Reset
REQ-030 rst_n low asynchronously forces: state IDLE, pixel_out 0, ts_out 0, epoch_out 0, err_count 0, all pulse outputs 0.
REQ-031 Reset mid-operation (including in MID_WAIT) discards any pending wrap; first packet after release handled per REQ-017.
REQ-032 Release of rst_n is synchronous to clk; first packet decoded on the first rising edge with rst_n high.

Verification
REQ-033 Reset, then packets 0x1234, 0x0ABC back-to-back -> pixel_valid two consecutive cycles, pixel_out 0x1234 then 0x0ABC, state STREAM.
REQ-034 STREAM, packet 0x8005 -> ts_valid, ts_out 0x00000005, epoch_out still 0.
REQ-035 Packets 0x8000 then 0x0003 consecutive -> no pixel_valid; epoch_valid with epoch_out 3; then 0x8010 -> ts_out {15'd3, 15'h0010} = 0x00018010.
REQ-036 0x8000, 3 idle cycles, 0x8000 -> err_pulse, err_count 1, still MID_WAIT; then 0x0007 -> epoch_out 7, state STREAM.
REQ-037 0x8000 then 0x9001 -> err_pulse and ts_valid same cycle, ts_out {epoch_out, 15'h1001}, state STREAM; 300 such errors -> err_count 255.
REQ-038 Assert rst_n low while in MID_WAIT, release, send 0x0001 -> pixel_valid with pixel_out 0x0001 (not decoded as epoch), epoch_out 0.

Source files
------------

// File: rtl/row_decoder_5p_plus.sv
// Row decoder for the 5P+ encoder stream.
// Splits incoming 16-bit packets into pixel groups, wake-up timestamps and
// epoch updates. A wrap marker (16'h8000) arms MID_WAIT, where the next
// packet carries the new epoch. Every output is registered, so each
// pulse/update shows up one cycle after the packet is sampled.
module row_decoder_5p_plus (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        packet_valid,
  input  logic [15:0] packet_in,
  output logic [14:0] pixel_out,
  output logic        pixel_valid,
  output logic [29:0] ts_out,
  output logic        ts_valid,
  output logic [14:0] epoch_out,
  output logic        epoch_valid,
  output logic        err_pulse,
  output logic [7:0]  err_count
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    STREAM   = 2'd1,
    MID_WAIT = 2'd2
  } state_t;

  state_t      state_reg, state_next;
  logic [14:0] pixel_reg, pixel_next;
  logic [29:0] ts_reg, ts_next;
  logic [14:0] epoch_reg, epoch_next;
  logic        pixel_valid_reg, pixel_valid_next;
  logic        ts_valid_reg, ts_valid_next;
  logic        epoch_valid_reg, epoch_valid_next;
  logic        err_reg, err_next;
  logic [7:0]  err_count_reg;

  logic is_wrap;
  logic is_ts;

  // The wrap marker has bit15 set but is never a timestamp.
  assign is_wrap = (packet_in == 16'h8000);
  assign is_ts   = packet_in[15] && !is_wrap;

  // Next-state and next-output decode; held values default to unchanged.
  always_comb begin
    state_next       = state_reg;
    pixel_next       = pixel_reg;
    ts_next          = ts_reg;
    epoch_next       = epoch_reg;
    pixel_valid_next = 1'b0;
    ts_valid_next    = 1'b0;
    epoch_valid_next = 1'b0;
    err_next         = 1'b0;
    if (packet_valid) begin
      case (state_reg)
        MID_WAIT: begin
          if (!packet_in[15]) begin
            // Epoch payload following a wrap marker.
            epoch_next       = packet_in[14:0];
            epoch_valid_next = 1'b1;
            state_next       = STREAM;
          end else if (is_wrap) begin
            // Back-to-back wrap: flag it, keep waiting for the epoch.
            err_next = 1'b1;
          end else begin
            // Timestamp instead of epoch: drop the wrap, decode with old epoch.
            err_next      = 1'b1;
            ts_next       = {epoch_reg, packet_in[14:0]};
            ts_valid_next = 1'b1;
            state_next    = STREAM;
          end
        end
        default: begin
          // IDLE decodes exactly like STREAM.
          if (is_wrap) begin
            state_next = MID_WAIT;
          end else if (is_ts) begin
            ts_next       = {epoch_reg, packet_in[14:0]};
            ts_valid_next = 1'b1;
            state_next    = STREAM;
          end else begin
            pixel_next       = packet_in[14:0];
            pixel_valid_next = 1'b1;
            state_next       = STREAM;
          end
        end
      endcase
    end
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      pixel_reg       <= '0;
      ts_reg          <= '0;
      epoch_reg       <= '0;
      pixel_valid_reg <= 1'b0;
      ts_valid_reg    <= 1'b0;
      epoch_valid_reg <= 1'b0;
      err_reg         <= 1'b0;
    end else begin
      state_reg       <= state_next;
      pixel_reg       <= pixel_next;
      ts_reg          <= ts_next;
      epoch_reg       <= epoch_next;
      pixel_valid_reg <= pixel_valid_next;
      ts_valid_reg    <= ts_valid_next;
      epoch_valid_reg <= epoch_valid_next;
      err_reg         <= err_next;
    end
  end

  // Saturating error counter, stepped in the same edge as err_pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count_reg <= '0;
    end else if (err_next && (err_count_reg != 8'hFF)) begin
      err_count_reg <= err_count_reg + 8'd1;
    end
  end

  assign pixel_out   = pixel_reg;
  assign pixel_valid = pixel_valid_reg;
  assign ts_out      = ts_reg;
  assign ts_valid    = ts_valid_reg;
  assign epoch_out   = epoch_reg;
  assign epoch_valid = epoch_valid_reg;
  assign err_pulse   = err_reg;
  assign err_count   = err_count_reg;

endmodule

// File: tb/tb_row_decoder_5p_plus.sv
// Table-driven bench for row_decoder_5p_plus: each record gives one packet
// slot and the full expected output set one cycle later.
module tb_row_decoder_5p_plus;

  logic        clk;
  logic        rst_n;
  logic        packet_valid;
  logic [15:0] packet_in;
  logic [14:0] pixel_out;
  logic        pixel_valid;
  logic [29:0] ts_out;
  logic        ts_valid;
  logic [14:0] epoch_out;
  logic        epoch_valid;
  logic        err_pulse;
  logic [7:0]  err_count;

  int vectors;
  int miscompares;

  typedef struct {
    logic        valid;
    logic [15:0] pkt;
    logic        pv;
    logic [14:0] pix;
    logic        tv;
    logic [29:0] ts;
    logic        ev;
    logic [14:0] ep;
    logic        err;
    logic [7:0]  cnt;
  } vec_t;

  vec_t tbl [19];
  vec_t cur;

  row_decoder_5p_plus dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .packet_valid (packet_valid),
    .packet_in    (packet_in),
    .pixel_out    (pixel_out),
    .pixel_valid  (pixel_valid),
    .ts_out       (ts_out),
    .ts_valid     (ts_valid),
    .epoch_out    (epoch_out),
    .epoch_valid  (epoch_valid),
    .err_pulse    (err_pulse),
    .err_count    (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(logic v, logic [15:0] p, logic pv, logic [14:0] pix,
                              logic tv, logic [29:0] ts, logic ev, logic [14:0] ep,
                              logic err, logic [7:0] cnt);
    vec_t r;
    r.valid = v; r.pkt = p; r.pv = pv; r.pix = pix; r.tv = tv; r.ts = ts;
    r.ev = ev; r.ep = ep; r.err = err; r.cnt = cnt;
    return r;
  endfunction

  // Compare every output against the record; also require pulse exclusivity.
  task automatic check(input string name, input vec_t e);
    int nv;
    nv = int'(pixel_valid) + int'(ts_valid) + int'(epoch_valid);
    vectors++;
    if (pixel_valid !== e.pv || pixel_out !== e.pix || ts_valid !== e.tv ||
        ts_out !== e.ts || epoch_valid !== e.ev || epoch_out !== e.ep ||
        err_pulse !== e.err || err_count !== e.cnt || nv > 1) begin
      miscompares++;
      $display("FAIL %s: got pv=%b pix=%h tv=%b ts=%h ev=%b ep=%h err=%b cnt=%0d, want pv=%b pix=%h tv=%b ts=%h ev=%b ep=%h err=%b cnt=%0d",
               name, pixel_valid, pixel_out, ts_valid, ts_out, epoch_valid, epoch_out,
               err_pulse, err_count, e.pv, e.pix, e.tv, e.ts, e.ev, e.ep, e.err, e.cnt);
    end else begin
      $display("ok   %s: pkt_v=%b pkt=%h pix=%h ts=%h ep=%h cnt=%0d",
               name, e.valid, e.pkt, pixel_out, ts_out, epoch_out, err_count);
    end
  endtask

  // Drive one slot at the falling edge, check one cycle after sampling.
  task automatic apply(input string name, input vec_t e);
    @(negedge clk);
    packet_valid = e.valid;
    packet_in    = e.pkt;
    @(posedge clk);
    #1;
    check(name, e);
  endtask

  initial begin
    vectors      = 0;
    miscompares  = 0;
    packet_valid = 1'b0;
    packet_in    = 16'h0000;
    rst_n        = 1'b0;

    //            v     pkt       pv pix       tv ts          ev ep      err cnt
    tbl[0]  = mk(1'b1, 16'h1234, 1, 15'h1234, 0, 30'h0,     0, 15'd0, 0, 8'd0);
    tbl[1]  = mk(1'b1, 16'h0ABC, 1, 15'h0ABC, 0, 30'h0,     0, 15'd0, 0, 8'd0);
    tbl[2]  = mk(1'b1, 16'h8005, 0, 15'h0ABC, 1, 30'h5,     0, 15'd0, 0, 8'd0);
    tbl[3]  = mk(1'b0, 16'h0000, 0, 15'h0ABC, 0, 30'h5,     0, 15'd0, 0, 8'd0);
    tbl[4]  = mk(1'b1, 16'h8000, 0, 15'h0ABC, 0, 30'h5,     0, 15'd0, 0, 8'd0);
    tbl[5]  = mk(1'b1, 16'h0003, 0, 15'h0ABC, 0, 30'h5,     1, 15'd3, 0, 8'd0);
    tbl[6]  = mk(1'b1, 16'h8010, 0, 15'h0ABC, 1, 30'h18010, 0, 15'd3, 0, 8'd0);
    tbl[7]  = mk(1'b1, 16'h8000, 0, 15'h0ABC, 0, 30'h18010, 0, 15'd3, 0, 8'd0);
    tbl[8]  = mk(1'b0, 16'h0000, 0, 15'h0ABC, 0, 30'h18010, 0, 15'd3, 0, 8'd0);
    tbl[9]  = mk(1'b0, 16'h1111, 0, 15'h0ABC, 0, 30'h18010, 0, 15'd3, 0, 8'd0);
    tbl[10] = mk(1'b0, 16'h8000, 0, 15'h0ABC, 0, 30'h18010, 0, 15'd3, 0, 8'd0);
    tbl[11] = mk(1'b1, 16'h8000, 0, 15'h0ABC, 0, 30'h18010, 0, 15'd3, 1, 8'd1);
    tbl[12] = mk(1'b1, 16'h0007, 0, 15'h0ABC, 0, 30'h18010, 1, 15'd7, 0, 8'd1);
    tbl[13] = mk(1'b1, 16'h0042, 1, 15'h0042, 0, 30'h18010, 0, 15'd7, 0, 8'd1);
    tbl[14] = mk(1'b1, 16'h8000, 0, 15'h0042, 0, 30'h18010, 0, 15'd7, 0, 8'd1);
    tbl[15] = mk(1'b1, 16'h9001, 0, 15'h0042, 1, 30'h39001, 0, 15'd7, 1, 8'd2);
    tbl[16] = mk(1'b1, 16'h0005, 1, 15'h0005, 0, 30'h39001, 0, 15'd7, 0, 8'd2);
    tbl[17] = mk(1'b1, 16'h7FFF, 1, 15'h7FFF, 0, 30'h39001, 0, 15'd7, 0, 8'd2);
    tbl[18] = mk(1'b1, 16'hFFFF, 0, 15'h7FFF, 1, 30'h3FFFF, 0, 15'd7, 0, 8'd2);

    // Reset state, checked while rst_n is still low.
    #12;
    check("reset", mk(1'b0, 16'h0, 0, 15'h0, 0, 30'h0, 0, 15'd0, 0, 8'd0));
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 19; i++) begin
      apply($sformatf("tbl%0d", i), tbl[i]);
    end

    // 300 wrap-then-timestamp errors; counter must stop at 255.
    cur = tbl[18];
    for (int i = 0; i < 300; i++) begin
      cur.valid = 1'b1; cur.pkt = 16'h8000;
      cur.pv = 0; cur.tv = 0; cur.ev = 0; cur.err = 0;
      apply($sformatf("sat_wrap%0d", i), cur);
      cur.pkt = 16'h9001;
      cur.tv  = 1;
      cur.ts  = {15'd7, 15'h1001};
      cur.err = 1;
      if (cur.cnt != 8'd255) cur.cnt = cur.cnt + 8'd1;
      apply($sformatf("sat_ts%0d", i), cur);
    end
    vectors++;
    if (err_count !== 8'd255) begin
      miscompares++;
      $display("FAIL sat_final: err_count=%0d want 255", err_count);
    end

    // Enter MID_WAIT, then reset asynchronously mid-cycle.
    cur.valid = 1'b1; cur.pkt = 16'h8000;
    cur.pv = 0; cur.tv = 0; cur.ev = 0; cur.err = 0;
    apply("mid_before_reset", cur);
    @(negedge clk);
    packet_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("async_reset", mk(1'b0, 16'h0, 0, 15'h0, 0, 30'h0, 0, 15'd0, 0, 8'd0));
    @(negedge clk);
    rst_n = 1'b1;
    apply("post_reset_pixel", mk(1'b1, 16'h0001, 1, 15'h0001, 0, 30'h0, 0, 15'd0, 0, 8'd0));
    apply("post_reset_wrap", mk(1'b1, 16'h8000, 0, 15'h0001, 0, 30'h0, 0, 15'd0, 0, 8'd0));
    apply("post_reset_epoch", mk(1'b1, 16'h0000, 0, 15'h0001, 0, 30'h0, 1, 15'd0, 0, 8'd0));

    @(negedge clk);
    packet_valid = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
